peripheral_dbg_soc_osd_mam_burst_split: RTL and testbench

Request splitter placed directly upstream of the MAM AHB4 bus interface. It accepts one memory-access request of up to 8191 beats from the MAM packet engine and re-issues it downstream as a sequence of incrementing bursts. Each burst is at most MAX_BEATS long and never crosses a 1 KiB address boundary (AHB rule). Write and read data pass through combinationally, gated by state, and the block counts them per burst.

---
 rtl/peripheral_dbg_soc_osd_mam_burst_split.sv | 157 +++++++++++++++
 tb/tb_peripheral_dbg_soc_osd_mam_burst_split.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_dbg_soc_osd_mam_burst_split.sv
// rtl/peripheral_dbg_soc_osd_mam_burst_split.sv - splits one long MAM access into bounded, 1 KiB-safe incrementing bursts
module peripheral_dbg_soc_osd_mam_burst_split #(
    parameter int XLEN      = 16,
    parameter int PLEN      = 32,
    parameter int MAX_BEATS = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              in_req_valid,
    output logic              in_req_ready,
    input  logic              in_req_we,
    input  logic              in_req_burst,
    input  logic [PLEN-1:0]   in_req_addr,
    input  logic [12:0]       in_req_beats,

    input  logic              in_write_valid,
    output logic              in_write_ready,
    input  logic [XLEN-1:0]   in_write_data,
    input  logic [XLEN/8-1:0] in_write_strb,

    output logic              in_read_valid,
    output logic [XLEN-1:0]   in_read_data,
    input  logic              in_read_ready,

    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_we,
    output logic              req_burst,
    output logic [PLEN-1:0]   req_addr,
    output logic [12:0]       req_beats,

    output logic              write_valid,
    input  logic              write_ready,
    output logic [XLEN-1:0]   write_data,
    output logic [XLEN/8-1:0] write_strb,

    input  logic              read_valid,
    output logic              read_ready,
    input  logic [XLEN-1:0]   read_data
);

    localparam int SW     = XLEN / 8;
    localparam int SW_LOG = $clog2(SW);

    typedef enum logic [1:0] {IDLE, ISSUE, DATA} state_t;

    state_t            state_q, state_d;
    logic              we_q, burst_q;
    logic [PLEN-1:0]   addr_q;
    logic [12:0]       rem_q, chunk_q, cnt_q;

    logic              active, beat, load, advance;
    logic [12:0]       in_beats, rem_next, chunk_next;
    logic [PLEN-1:0]   addr_next;

    // Beats until the next 1 KiB boundary, capped by MAX_BEATS and what is left.
    function automatic logic [12:0] chunk_of(input logic burst, input logic [12:0] rem,
                                             input logic [9:0] addr_lo);
        logic [10:0] wtb;
        logic [12:0] c;
        wtb = (11'd1024 - {1'b0, addr_lo}) >> SW_LOG;
        if (!burst) begin
            c = 13'd1;
        end else begin
            c = rem;
            if (c > 13'(MAX_BEATS)) c = 13'(MAX_BEATS);
            if (c > {2'b00, wtb})   c = {2'b00, wtb};
        end
        return c;
    endfunction

    // A zero beat count in the active states blocks further handshakes.
    assign active = (state_q != IDLE) && (cnt_q != 13'd0);

    assign write_valid    = active & we_q & in_write_valid;
    assign in_write_ready = active & we_q & write_ready;
    assign write_data     = in_write_data;
    assign write_strb     = in_write_strb;

    assign in_read_valid  = active & ~we_q & read_valid;
    assign read_ready     = active & ~we_q & in_read_ready;
    assign in_read_data   = read_data;

    assign beat = we_q ? (write_valid & write_ready) : (in_read_valid & read_ready);

    assign in_req_ready = (state_q == IDLE);
    assign req_valid    = (state_q == ISSUE);
    assign req_we       = we_q;
    assign req_burst    = burst_q;
    assign req_addr     = addr_q;
    assign req_beats    = chunk_q;

    assign in_beats  = (in_req_beats == 13'd0) ? 13'd1 : in_req_beats;
    assign rem_next  = rem_q - chunk_q;
    assign addr_next = addr_q + (PLEN'(chunk_q) << SW_LOG);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        advance = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_req_valid) begin
                    load    = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (req_ready) state_d = DATA;
            end
            DATA: begin
                if ((cnt_q == 13'd0) || ((cnt_q == 13'd1) && beat)) begin
                    advance = 1'b1;
                    state_d = (rem_next == 13'd0) ? IDLE : ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        chunk_next = 13'd0;
        if (load) chunk_next = chunk_of(in_req_burst, in_beats, in_req_addr[9:0]);
        else      chunk_next = chunk_of(burst_q, rem_next, addr_next[9:0]);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            burst_q <= 1'b0;
            addr_q  <= '0;
            rem_q   <= '0;
            chunk_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                we_q    <= in_req_we;
                burst_q <= in_req_burst;
                addr_q  <= in_req_addr;
                rem_q   <= in_beats;
                chunk_q <= chunk_next;
                cnt_q   <= chunk_next;
            end else if (advance) begin
                addr_q  <= addr_next;
                rem_q   <= rem_next;
                chunk_q <= chunk_next;
                cnt_q   <= chunk_next;
            end else if (beat) begin
                cnt_q   <= cnt_q - 13'd1;
            end
        end
    end

endmodule

// File: tb/tb_peripheral_dbg_soc_osd_mam_burst_split.sv
// tb/tb_peripheral_dbg_soc_osd_mam_burst_split.sv - directed bench for the MAM burst splitter
module tb_peripheral_dbg_soc_osd_mam_burst_split;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_req_valid, in_req_ready, in_req_we, in_req_burst;
    logic [31:0] in_req_addr;
    logic [12:0] in_req_beats;
    logic        in_write_valid, in_write_ready;
    logic [15:0] in_write_data;
    logic [1:0]  in_write_strb;
    logic        in_read_valid, in_read_ready;
    logic [15:0] in_read_data;
    logic        req_valid, req_ready, req_we, req_burst;
    logic [31:0] req_addr;
    logic [12:0] req_beats;
    logic        write_valid, write_ready;
    logic [15:0] write_data;
    logic [1:0]  write_strb;
    logic        read_valid, read_ready;
    logic [15:0] read_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    peripheral_dbg_soc_osd_mam_burst_split #(.XLEN(16), .PLEN(32), .MAX_BEATS(16)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_req_valid(in_req_valid), .in_req_ready(in_req_ready), .in_req_we(in_req_we),
        .in_req_burst(in_req_burst), .in_req_addr(in_req_addr), .in_req_beats(in_req_beats),
        .in_write_valid(in_write_valid), .in_write_ready(in_write_ready),
        .in_write_data(in_write_data), .in_write_strb(in_write_strb),
        .in_read_valid(in_read_valid), .in_read_data(in_read_data), .in_read_ready(in_read_ready),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_burst(req_burst),
        .req_addr(req_addr), .req_beats(req_beats),
        .write_valid(write_valid), .write_ready(write_ready), .write_data(write_data),
        .write_strb(write_strb),
        .read_valid(read_valid), .read_ready(read_ready), .read_data(read_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        in_req_valid   = 1'b0;
        req_ready      = 1'b0;
        in_write_valid = 1'b0;
        write_ready    = 1'b0;
        read_valid     = 1'b0;
        in_read_ready  = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic burst, input logic [31:0] addr,
                          input logic [12:0] beats);
        @(negedge clk);
        clear_inputs();
        in_req_valid = 1'b1;
        in_req_we    = we;
        in_req_burst = burst;
        in_req_addr  = addr;
        in_req_beats = beats;
        #1;
        check("in_req_ready_accept", in_req_ready, 1);
    endtask

    // Waits up to maxw extra cycles for req_valid, checks the request, accepts it at the next edge.
    task automatic wait_req(input logic [31:0] addr, input logic [12:0] beats,
                            input logic burst, input int maxw);
        int w;
        @(negedge clk);
        clear_inputs();
        #1;
        w = 0;
        while (!req_valid && w < maxw) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("req_valid", req_valid, 1);
        check("req_addr", req_addr, addr);
        check("req_beats", 32'(req_beats), 32'(beats));
        check("req_burst", req_burst, burst);
        req_ready = 1'b1;
    endtask

    task automatic read_beats(input int n, input logic [15:0] base, input int stall_at);
        for (int k = 0; k < n; k++) begin
            if (k == stall_at) begin
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    clear_inputs();
                    read_valid = 1'b1;
                    read_data  = base + 16'(k);
                    #1;
                    check("rd_stall_ready", read_ready, 0);
                    check("rd_stall_noreq", req_valid, 0);
                end
            end
            @(negedge clk);
            clear_inputs();
            read_valid    = 1'b1;
            read_data     = base + 16'(k);
            in_read_ready = 1'b1;
            #1;
            check("rd_valid", in_read_valid, 1);
            check("rd_ready", read_ready, 1);
            check("rd_data", 32'(in_read_data), 32'(base + 16'(k)));
            check("rd_noreq", req_valid, 0);
        end
    endtask

    task automatic write_beats(input int n, input logic [15:0] base, input int stall_at);
        for (int k = 0; k < n; k++) begin
            if (k == stall_at) begin
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    clear_inputs();
                    in_write_valid = 1'b1;
                    in_write_data  = base + 16'(k);
                    #1;
                    check("wr_stall_ready", in_write_ready, 0);
                    check("wr_stall_noreq", req_valid, 0);
                end
            end
            @(negedge clk);
            clear_inputs();
            in_write_valid = 1'b1;
            in_write_data  = base + 16'(k);
            in_write_strb  = 2'b11;
            write_ready    = 1'b1;
            #1;
            check("wr_valid", write_valid, 1);
            check("wr_ready", in_write_ready, 1);
            check("wr_data", 32'(write_data), 32'(base + 16'(k)));
            check("wr_noreq", req_valid, 0);
        end
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        clear_inputs();
        #1;
        check({tag, "_in_req_ready"}, in_req_ready, 1);
        check({tag, "_req_valid"}, req_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        in_req_we = 1'b0; in_req_burst = 1'b0; in_req_addr = '0; in_req_beats = '0;
        in_write_data = '0; in_write_strb = '0; read_data = '0;

        // Reset state, with upstream/downstream valids asserted to prove gating
        repeat (2) @(posedge clk);
        @(negedge clk);
        read_valid = 1'b1; in_read_ready = 1'b1; in_write_valid = 1'b1; write_ready = 1'b1;
        #1;
        check("rst_req_valid", req_valid, 0);
        check("rst_write_valid", write_valid, 0);
        check("rst_in_write_ready", in_write_ready, 0);
        check("rst_in_read_valid", in_read_valid, 0);
        check("rst_read_ready", read_ready, 0);
        rst_n = 1'b1;
        clear_inputs();
        check_idle("post_rst");

        // Single write with a same-cycle data handshake during ISSUE
        do_req(1'b1, 1'b0, 32'h100, 13'd1);
        @(negedge clk);
        clear_inputs();
        #1;
        check("sw_req_valid", req_valid, 1);
        check("sw_req_addr", req_addr, 32'h100);
        check("sw_req_burst", req_burst, 0);
        check("sw_req_beats", 32'(req_beats), 1);
        check("sw_req_we", req_we, 1);
        check("sw_in_req_ready", in_req_ready, 0);
        @(negedge clk);
        req_ready = 1'b1; in_write_valid = 1'b1; in_write_data = 16'hA5A5;
        in_write_strb = 2'b01; write_ready = 1'b1;
        #1;
        check("sw_req_stable", req_addr, 32'h100);
        check("sw_wr_valid", write_valid, 1);
        check("sw_wr_data", 32'(write_data), 32'hA5A5);
        check("sw_wr_strb", 32'(write_strb), 32'h1);
        check("sw_wr_ready", in_write_ready, 1);
        @(negedge clk);
        req_ready = 1'b0;
        #1;
        check("sw_blocked_valid", write_valid, 0);
        check("sw_blocked_ready", in_write_ready, 0);
        check("sw_no_reissue", req_valid, 0);
        check_idle("sw");

        // Split read: 40 beats at 0x0
        do_req(1'b0, 1'b1, 32'h0, 13'd40);
        wait_req(32'h000, 13'd16, 1'b1, 0);
        read_beats(16, 16'h1000, -1);
        wait_req(32'h020, 13'd16, 1'b1, 0);
        read_beats(16, 16'h1010, -1);
        wait_req(32'h040, 13'd8, 1'b1, 0);
        read_beats(8, 16'h1020, -1);
        check_idle("split");

        // 1 KiB boundary write with downstream backpressure in the second chunk
        do_req(1'b1, 1'b1, 32'h3FC, 13'd10);
        wait_req(32'h3FC, 13'd2, 1'b1, 0);
        write_beats(2, 16'h2000, -1);
        wait_req(32'h400, 13'd8, 1'b1, 0);
        write_beats(8, 16'h2002, 3);
        check_idle("kib");

        // Zero beats treated as one
        do_req(1'b0, 1'b1, 32'h80, 13'd0);
        wait_req(32'h80, 13'd1, 1'b1, 0);
        read_beats(1, 16'h3000, -1);
        check_idle("zero");

        // Upstream read backpressure mid-chunk
        do_req(1'b0, 1'b1, 32'h200, 13'd16);
        wait_req(32'h200, 13'd16, 1'b1, 0);
        read_beats(16, 16'h4000, 7);
        check_idle("bp");

        // Reset during DATA of chunk 2
        do_req(1'b0, 1'b1, 32'h0, 13'd40);
        wait_req(32'h000, 13'd16, 1'b1, 0);
        read_beats(16, 16'h5000, -1);
        wait_req(32'h020, 13'd16, 1'b1, 0);
        read_beats(3, 16'h5010, -1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        read_valid = 1'b1; in_read_ready = 1'b1;
        #1;
        check("mid_rst_req_valid", req_valid, 0);
        check("mid_rst_in_read_valid", in_read_valid, 0);
        check("mid_rst_read_ready", read_ready, 0);
        check("mid_rst_in_req_ready", in_req_ready, 1);
        check_idle("mid_rst_quiet");
        do_req(1'b0, 1'b0, 32'h10, 13'd1);
        wait_req(32'h10, 13'd1, 1'b0, 0);
        read_beats(1, 16'h6000, -1);
        check_idle("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
